// File: rtl/division_unit_pkg.sv
// division_unit_pkg: opcode and state encodings shared by the divider files
package division_unit_pkg;
  localparam logic [1:0] DIV_OP_DIV  = 2'b00;
  localparam logic [1:0] DIV_OP_DIVU = 2'b01;
  localparam logic [1:0] DIV_OP_REM  = 2'b10;
  localparam logic [1:0] DIV_OP_REMU = 2'b11;
  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;
endpackage

// File: rtl/division_step.sv
// division_step: one radix-2 restoring shift-and-trial-subtract iteration
module division_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem_i,
  input  logic [XLEN-1:0] quo_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN-1:0] rem_o,
  output logic [XLEN-1:0] quo_o
);
  logic [XLEN:0] diff;
  // Shift {rem,quo} left, subtract divisor; the extra top bit flags a negative trial
  always_comb begin
    diff  = {rem_i, quo_i[XLEN-1]} - {1'b0, divisor_i};
    rem_o = diff[XLEN] ? {rem_i[XLEN-2:0], quo_i[XLEN-1]} : diff[XLEN-1:0];
    quo_o = {quo_i[XLEN-2:0], ~diff[XLEN]};
  end
endmodule

// File: rtl/division_unit.sv
// division_unit: multi-cycle RV32M DIV/DIVU/REM/REMU with pipeline stall request.
// Optional macro DIVIDER_RESULT_CACHE_EN keeps the last operands and both results.
module division_unit
  import division_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            en_i,
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  input  logic            stall_execute_stage_i,
  input  logic            flush_i,
  output logic [XLEN-1:0] result_o,
  output logic            result_valid_o,
  output logic            en_stall_execute_stage_o
);
  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};
  div_state_e state_q;
  logic [XLEN-1:0] rem_q, quo_q, dvs_q, result_q;
  logic [CW-1:0] cnt_q;
  logic rem_sel_q, neg_q_q, neg_r_q, valid_q;
  logic sgn, a_neg, b_neg, div_zero, ovf, spc, hit, last;
  logic [XLEN-1:0] abs_a, abs_b, spc_quo, spc_rem, spc_res, hit_res;
  logic [XLEN-1:0] rem_n, quo_n, fin_q, fin_r;

  division_step #(.XLEN(XLEN)) u_step (
    .rem_i(rem_q), .quo_i(quo_q), .divisor_i(dvs_q), .rem_o(rem_n), .quo_o(quo_n)
  );

  // Operand magnitudes, single-cycle special results and final sign fix-up
  always_comb begin
    sgn      = ~op_i[0];
    a_neg    = sgn & dividend_i[XLEN-1];
    b_neg    = sgn & divisor_i[XLEN-1];
    abs_a    = a_neg ? -dividend_i : dividend_i;
    abs_b    = b_neg ? -divisor_i : divisor_i;
    div_zero = divisor_i == '0;
    ovf      = sgn && dividend_i == MIN && divisor_i == '1;
    spc_quo  = div_zero ? '1 : MIN;
    spc_rem  = div_zero ? dividend_i : '0;
    spc      = hit | div_zero | ovf;
    spc_res  = hit ? hit_res : op_i[1] ? spc_rem : spc_quo;
    last     = state_q == DIV_CALC && cnt_q == CW'(1);
    fin_q    = neg_q_q ? -quo_n : quo_n;
    fin_r    = neg_r_q ? -rem_n : rem_n;
  end

  assign en_stall_execute_stage_o = !flush_i && (state_q == DIV_CALC || (state_q == DIV_IDLE && en_i));
  assign result_o       = result_q;
  assign result_valid_o = valid_q;

  // Control FSM and datapath registers; flush beats en_i and the execute stall
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q   <= DIV_IDLE;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      cnt_q     <= '0;
      rem_sel_q <= 1'b0;
      neg_q_q   <= 1'b0;
      neg_r_q   <= 1'b0;
      result_q  <= '0;
      valid_q   <= 1'b0;
    end else if (flush_i) begin
      state_q <= DIV_IDLE;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        DIV_IDLE: if (en_i) begin
          rem_q     <= '0;
          quo_q     <= abs_a;
          dvs_q     <= abs_b;
          cnt_q     <= CW'(XLEN);
          rem_sel_q <= op_i[1];
          neg_q_q   <= a_neg ^ b_neg;
          neg_r_q   <= a_neg;
          state_q   <= spc ? DIV_DONE : DIV_CALC;
          valid_q   <= spc;
          if (spc) result_q <= spc_res;
        end
        DIV_CALC: begin
          rem_q <= rem_n;
          quo_q <= quo_n;
          cnt_q <= cnt_q - CW'(1);
          if (last) begin
            state_q  <= DIV_DONE;
            valid_q  <= 1'b1;
            result_q <= rem_sel_q ? fin_r : fin_q;
          end
        end
        DIV_DONE: if (!stall_execute_stage_i) begin
          state_q <= DIV_IDLE;
          valid_q <= 1'b0;
        end
        default: state_q <= DIV_IDLE;
      endcase
    end
  end

`ifdef DIVIDER_RESULT_CACHE_EN
  logic c_vld_q, c_sgn_q;
  logic [XLEN-1:0] c_dvd_q, c_dvs_q, c_quo_q, c_rem_q;
  assign hit     = c_vld_q && c_dvd_q == dividend_i && c_dvs_q == divisor_i && c_sgn_q == sgn;
  assign hit_res = op_i[1] ? c_rem_q : c_quo_q;
  // Operands latch at start; special cases are valid at once, iterated ones on completion
  always_ff @(posedge clk_i) begin
    if (!rst_i || flush_i) begin
      c_vld_q <= 1'b0;
    end else if (state_q == DIV_IDLE && en_i && !hit) begin
      c_vld_q <= div_zero | ovf;
      c_dvd_q <= dividend_i;
      c_dvs_q <= divisor_i;
      c_sgn_q <= sgn;
      c_quo_q <= spc_quo;
      c_rem_q <= spc_rem;
    end else if (last) begin
      c_vld_q <= 1'b1;
      c_quo_q <= fin_q;
      c_rem_q <= fin_r;
    end
  end
`else
  assign hit     = 1'b0;
  assign hit_res = '0;
`endif
endmodule

// File: tb/tb_division_unit.sv
// tb_division_unit: randomized and directed checks of division_unit against an arithmetic model
module tb_division_unit;
  logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, stall_i = 1'b0, flush = 1'b0;
  logic [1:0] op = 2'b00;
  logic [31:0] a = '0, b = '0;
  logic [31:0] res;
  logic vld, stall_o;
  int checks = 0, failures = 0;
  bit c_vld = 1'b0, c_s = 1'b0;
  logic [31:0] c_a = '0, c_b = '0;
`ifdef DIVIDER_RESULT_CACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif

  division_unit #(.XLEN(32)) dut (
    .clk_i(clk), .rst_i(rst_n), .en_i(en), .op_i(op), .dividend_i(a), .divisor_i(b),
    .stall_execute_stage_i(stall_i), .flush_i(flush), .result_o(res),
    .result_valid_o(vld), .en_stall_execute_stage_o(stall_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_div(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    logic s, r;
    s = ~o[0];
    r = o[1];
    if (y == 0) return r ? x : 32'hFFFF_FFFF;
    if (s && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return r ? 32'h0 : 32'h8000_0000;
    if (s) return r ? 32'($signed(x) % $signed(y)) : 32'($signed(x) / $signed(y));
    return r ? x % y : x / y;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input int hold, input bit en_done);
    logic [31:0] exp;
    bit s, hit, stall_ok;
    int n, lat;
    s = ~o[0];
    exp = ref_div(o, x, y);
    hit = CACHE && c_vld && x == c_a && y == c_b && s == c_s;
    lat = (hit || y == 0 || (s && x == 32'h8000_0000 && y == 32'hFFFF_FFFF)) ? 1 : 33;
    op = o; a = x; b = y; en = 1'b1;
    #1;
    chk("stall_T", stall_o, 1);
    cyc();
    en = 1'b0;
    n = 1;
    stall_ok = 1'b1;
    while (!vld && n < 40) begin
      if (!stall_o) stall_ok = 1'b0;
      cyc();
      n++;
    end
    chk("latency", n, lat);
    chk("stall_calc", stall_ok, 1);
    chk("result", res, exp);
    chk("stall_done", stall_o, 0);
    c_vld = 1'b1; c_a = x; c_b = y; c_s = s;
    stall_i = hold > 0;
    en = en_done;
    for (int h = 0; h < hold; h++) begin
      cyc();
      chk("hold_valid", vld, 1);
      chk("hold_result", res, exp);
    end
    stall_i = 1'b0;
    cyc();
    en = 1'b0;
    chk("release_valid", vld, 0);
    chk("release_result", res, exp);
  endtask

  initial begin
    logic [31:0] px, py, x, y;
    bit seen;
    repeat (2) cyc();
    chk("rst_result", res, 0);
    chk("rst_valid", vld, 0);
    chk("rst_stall", stall_o, 0);
    rst_n = 1'b1;
    cyc();
    chk("idle_no_en", vld, 0);
    run_op(2'b01, 100, 7, 0, 0);
    run_op(2'b11, 100, 7, 0, 0);
    run_op(2'b00, 100, 7, 0, 0);
    run_op(2'b10, 100, 7, 0, 0);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    c_vld = 1'b0;
    run_op(2'b10, 100, 7, 0, 0);
    run_op(2'b00, 32'hFFFF_FFF9, 2, 0, 0);
    run_op(2'b10, 32'hFFFF_FFF9, 2, 0, 0);
    run_op(2'b00, 5, 0, 0, 0);
    run_op(2'b10, 5, 0, 0, 0);
    run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
    run_op(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
    run_op(2'b01, 1000, 3, 3, 1);
    op = 2'b01; a = 32'd123456; b = 32'd11; en = 1'b1;
    cyc();
    en = 1'b0;
    repeat (9) cyc();
    flush = 1'b1;
    #1;
    chk("flush_stall", stall_o, 0);
    cyc();
    flush = 1'b0;
    c_vld = 1'b0;
    chk("flush_valid", vld, 0);
    seen = 1'b0;
    repeat (40) begin
      cyc();
      if (vld || stall_o) seen = 1'b1;
    end
    chk("flush_quiet", seen, 0);
    op = 2'b00; a = 32'd999; b = 32'd4; en = 1'b1;
    cyc();
    en = 1'b0;
    repeat (4) cyc();
    rst_n = 1'b0;
    cyc();
    chk("rst_mid_result", res, 0);
    chk("rst_mid_valid", vld, 0);
    chk("rst_mid_stall", stall_o, 0);
    rst_n = 1'b1;
    c_vld = 1'b0;
    cyc();
    px = 32'd17; py = 32'd5;
    for (int i = 0; i < 40; i++) begin
      int sel;
      sel = $urandom_range(0, 9);
      x = $urandom;
      y = $urandom >> $urandom_range(0, 31);
      if (sel == 0) y = 0;
      if (sel == 1) begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
      if (sel == 2) begin x = px; y = py; end
      run_op(2'($urandom_range(0, 3)), x, y, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
      px = x; py = y;
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
